// File: rtl/instr_rx_pkg.sv
// Shared types and constants for the instruction burst receiver.
package instr_rx_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM
    } rx_state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_CSUM  = 2'b01;
    localparam logic [1:0] ERR_OVF   = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

    // True once a frame has started and until it ends.
    function automatic logic in_frame(input rx_state_e s);
        return (s == ST_ADDR) || (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/instr_rx_asm.sv
// Byte-to-word shift assembler; word_c_o already includes the byte shifted in this cycle.
module instr_rx_asm
    import instr_rx_pkg::*;
#(
    parameter int unsigned W          = 32,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [W-1:0]      word_c_o
);

    logic [W-1:0] word_q;
    logic [W-1:0] shifted;

    generate
        if (W == BYTE_W) begin : g_single
            assign shifted = byte_i;
        end else if (BIG_ENDIAN) begin : g_be
            assign shifted = {word_q[W-BYTE_W-1:0], byte_i};
        end else begin : g_le
            assign shifted = {byte_i, word_q[W-1:BYTE_W]};
        end
    endgenerate

    assign word_c_o = shift_en_i ? shifted : word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_c_o;
        end
    end

endmodule

// File: rtl/instr_burst_rx.sv
// Receives address/length/data/checksum byte frames and emits word write requests.
module instr_burst_rx
    import instr_rx_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b0,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              win_open,
    input  logic              win_close,
    input  logic [7:0]        data_in_rx,
    input  logic              rx_data_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code
);

    localparam int unsigned AB    = ADDR_W / BYTE_W;
    localparam int unsigned DB    = DATA_W / BYTE_W;
    localparam int unsigned MAXB  = (AB > DB) ? AB : DB;
    localparam int unsigned CNT_W = $clog2(MAXB + 1);
    localparam int unsigned TO_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    rx_state_e         state_q, state_d;
    logic              rx_q;
    logic [CNT_W-1:0]  bcnt_q, bcnt_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        csum_q, csum_d;
    logic              ovf_q, ovf_d;
    logic [TO_W-1:0]   tmo_q, tmo_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_valid_q, wr_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;

    logic              byte_stb;
    logic              addr_shift;
    logic              data_shift;
    logic              word_done;
    logic              tmo_hit;
    logic [ADDR_W-1:0] addr_word;
    logic [DATA_W-1:0] data_word;

    assign byte_stb   = rx_data_valid & ~rx_q;
    assign addr_shift = byte_stb && ((state_q == ST_HUNT) || (state_q == ST_ADDR));
    assign data_shift = byte_stb && (state_q == ST_DATA);
    assign tmo_hit    = (TIMEOUT != 0) && in_frame(state_q) && !byte_stb &&
                        (tmo_q == TO_W'(TIMEOUT - 1));

    instr_rx_asm #(.W(ADDR_W), .BIG_ENDIAN(BIG_ENDIAN)) u_addr_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (addr_shift),
        .byte_i     (data_in_rx),
        .word_c_o   (addr_word)
    );

    instr_rx_asm #(.W(DATA_W), .BIG_ENDIAN(BIG_ENDIAN)) u_data_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (data_shift),
        .byte_i     (data_in_rx),
        .word_c_o   (data_word)
    );

    // Next-state, frame bookkeeping and write-port logic.
    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        wcnt_d     = wcnt_q;
        len_d      = len_q;
        csum_d     = csum_q;
        ovf_d      = ovf_q;
        tmo_d      = '0;
        cur_addr_d = cur_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = wr_valid_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        code_d     = ERR_NONE;
        word_done  = 1'b0;

        if ((TIMEOUT != 0) && in_frame(state_q) && !byte_stb) begin
            tmo_d = tmo_q + TO_W'(1);
        end

        // Window events outrank the timeout, which outranks byte handling.
        if (win_open || win_close || tmo_hit) begin
            state_d = win_open ? ST_HUNT : (win_close ? ST_IDLE : ST_HUNT);
            bcnt_d  = '0;
            wcnt_d  = '0;
            csum_d  = '0;
            ovf_d   = 1'b0;
            tmo_d   = '0;
            if (!win_open && in_frame(state_q)) begin
                err_d  = 1'b1;
                code_d = ERR_ABORT;
            end
        end else if (byte_stb) begin
            case (state_q)
                ST_HUNT: begin
                    csum_d = data_in_rx;
                    if (AB == 1) begin
                        state_d    = ST_LEN;
                        cur_addr_d = addr_word;
                        bcnt_d     = '0;
                    end else begin
                        state_d = ST_ADDR;
                        bcnt_d  = CNT_W'(1);
                    end
                end
                ST_ADDR: begin
                    csum_d = csum_q ^ data_in_rx;
                    if (bcnt_q == CNT_W'(AB - 1)) begin
                        state_d    = ST_LEN;
                        cur_addr_d = addr_word;
                        bcnt_d     = '0;
                    end else begin
                        bcnt_d = bcnt_q + CNT_W'(1);
                    end
                end
                ST_LEN: begin
                    csum_d  = csum_q ^ data_in_rx;
                    len_d   = data_in_rx;
                    wcnt_d  = '0;
                    bcnt_d  = '0;
                    state_d = (data_in_rx == 8'd0) ? ST_CSUM : ST_DATA;
                end
                ST_DATA: begin
                    csum_d = csum_q ^ data_in_rx;
                    if (bcnt_q == CNT_W'(DB - 1)) begin
                        bcnt_d     = '0;
                        word_done  = 1'b1;
                        cur_addr_d = cur_addr_q + ADDR_W'(DB);
                        wcnt_d     = wcnt_q + 8'd1;
                        if ((wcnt_q + 8'd1) == len_q) begin
                            state_d = ST_CSUM;
                        end
                    end else begin
                        bcnt_d = bcnt_q + CNT_W'(1);
                    end
                end
                ST_CSUM: begin
                    state_d = ST_HUNT;
                    done_d  = 1'b1;
                    if (ovf_q) begin
                        err_d  = 1'b1;
                        code_d = ERR_OVF;
                    end else if (data_in_rx != csum_q) begin
                        err_d  = 1'b1;
                        code_d = ERR_CSUM;
                    end
                    bcnt_d = '0;
                    wcnt_d = '0;
                    csum_d = '0;
                    ovf_d  = 1'b0;
                end
                default: ;
            endcase
        end

        // A presented word is never cancelled; a word finishing behind a stalled one is dropped.
        if (word_done && wr_valid_q && !wr_ready) begin
            ovf_d = 1'b1;
        end else if (word_done) begin
            wr_addr_d  = cur_addr_q;
            wr_data_d  = data_word;
            wr_valid_d = 1'b1;
        end else if (wr_valid_q && wr_ready) begin
            wr_valid_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rx_q       <= 1'b0;
            bcnt_q     <= '0;
            wcnt_q     <= '0;
            len_q      <= '0;
            csum_q     <= '0;
            ovf_q      <= 1'b0;
            tmo_q      <= '0;
            cur_addr_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            rx_q       <= rx_data_valid;
            bcnt_q     <= bcnt_d;
            wcnt_q     <= wcnt_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
            cur_addr_q <= cur_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_valid   = wr_valid_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign err_code   = code_q;

endmodule

// File: tb/tb_instr_burst_rx.sv
// Scoreboard bench: little-endian 32/32 receiver (TIMEOUT=50) and big-endian 16/16 receiver.
module tb_instr_burst_rx;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic       done;
        logic       err;
        logic [1:0] code;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        win_open_a = 1'b0, win_close_a = 1'b0;
    logic        win_open_b = 1'b0, win_close_b = 1'b0;
    logic [7:0]  data_in_rx = 8'h00;
    logic        rx_data_valid = 1'b0;
    logic        wr_ready = 1'b0;

    logic [31:0] wr_addr_a, wr_data_a;
    logic        wr_valid_a, busy_a, frame_done_a, frame_err_a;
    logic [1:0]  err_code_a;
    logic [15:0] wr_addr_b, wr_data_b;
    logic        wr_valid_b, busy_b, frame_done_b, frame_err_b;
    logic [1:0]  err_code_b;

    wr_t exp_wr_a[$];
    wr_t exp_wr_b[$];
    ev_t exp_ev_a[$];
    ev_t exp_ev_b[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned byte_cyc = 0;
    int unsigned last_ev_cyc_a = 0;

    instr_burst_rx #(.ADDR_W(32), .DATA_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(50)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .win_open(win_open_a), .win_close(win_close_a),
        .data_in_rx(data_in_rx), .rx_data_valid(rx_data_valid),
        .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_valid(wr_valid_a), .wr_ready(wr_ready),
        .busy(busy_a), .frame_done(frame_done_a), .frame_err(frame_err_a), .err_code(err_code_a)
    );

    instr_burst_rx #(.ADDR_W(16), .DATA_W(16), .BIG_ENDIAN(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .win_open(win_open_b), .win_close(win_close_b),
        .data_in_rx(data_in_rx), .rx_data_valid(rx_data_valid),
        .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_valid(wr_valid_b), .wr_ready(wr_ready),
        .busy(busy_b), .frame_done(frame_done_b), .frame_err(frame_err_b), .err_code(err_code_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT output with nothing expected at cycle %0d", name, cyc);
    endtask

    // Monitor: pops expectations whenever a DUT presents a transfer or frame event.
    always @(negedge clk) begin
        wr_t w;
        ev_t e;
        if (wr_valid_a && wr_ready) begin
            if (exp_wr_a.size() == 0) unexpected("write_a");
            else begin
                w = exp_wr_a.pop_front();
                check("write_a_addr", 64'(wr_addr_a), 64'(w.addr));
                check("write_a_data", 64'(wr_data_a), 64'(w.data));
            end
        end
        if (wr_valid_b && wr_ready) begin
            if (exp_wr_b.size() == 0) unexpected("write_b");
            else begin
                w = exp_wr_b.pop_front();
                check("write_b_addr", 64'(wr_addr_b), 64'(w.addr));
                check("write_b_data", 64'(wr_data_b), 64'(w.data));
            end
        end
        if (frame_done_a || frame_err_a) begin
            last_ev_cyc_a = cyc;
            if (exp_ev_a.size() == 0) unexpected("frame_event_a");
            else begin
                e = exp_ev_a.pop_front();
                check("frame_event_a", 64'({frame_done_a, frame_err_a, err_code_a}), 64'(e));
            end
        end
        if (frame_done_b || frame_err_b) begin
            if (exp_ev_b.size() == 0) unexpected("frame_event_b");
            else begin
                e = exp_ev_b.pop_front();
                check("frame_event_b", 64'({frame_done_b, frame_err_b, err_code_b}), 64'(e));
            end
        end
        if (!frame_err_a) check("err_code_idle_a", 64'(err_code_a), 64'(0));
        if (!frame_err_b) check("err_code_idle_b", 64'(err_code_b), 64'(0));
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_in_rx    = b;
        rx_data_valid = 1'b1;
        byte_cyc      = cyc;
        tick();
        rx_data_valid = 1'b0;
        tick();
    endtask

    task automatic send_bytes(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    function automatic logic [7:0] xor_all(input logic [7:0] q[$]);
        logic [7:0] x = 8'h00;
        foreach (q[i]) x ^= q[i];
        return x;
    endfunction

    task automatic drain(input string name);
        for (int i = 0; i < 40 &&
             (exp_wr_a.size() + exp_wr_b.size() + exp_ev_a.size() + exp_ev_b.size()) != 0; i++)
            tick();
        check({name, "_pending_expectations"},
              64'(exp_wr_a.size() + exp_wr_b.size() + exp_ev_a.size() + exp_ev_b.size()), 64'(0));
    endtask

    task automatic push_good_writes_a();
        exp_wr_a.push_back('{addr: 32'h0000_1000, data: 32'h9350_0013});
        exp_wr_a.push_back('{addr: 32'h0000_1004, data: 32'h1300_0000});
    endtask

    initial begin
        logic [7:0] fr_good[$];
        logic [7:0] fr_bad[$];
        logic [7:0] fr_b[$];
        int unsigned d;

        fr_good = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h02,
                    8'h13, 8'h00, 8'h50, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13};
        fr_good.push_back(xor_all(fr_good));
        check("hand_checksum", 64'(fr_good[13]), 64'(8'hD1));
        fr_bad = fr_good;
        fr_bad[13] = fr_bad[13] ^ 8'h01;
        fr_b = '{8'hFF, 8'hFE, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        fr_b.push_back(xor_all(fr_b));

        tick(3);
        check("reset_wr_valid", 64'(wr_valid_a), 64'(0));
        check("reset_outputs", 64'({wr_addr_a, wr_data_a}), 64'(0));
        check("reset_flags", 64'({busy_a, frame_done_a, frame_err_a, err_code_a, busy_b}), 64'(0));
        rst_n = 1'b1;
        tick(2);

        // Bytes before any win_open are ignored.
        send_byte(8'h55);
        check("idle_ignores_bytes", 64'(busy_a), 64'(0));

        wr_ready = 1'b1;
        win_open_a = 1'b1; tick(); win_open_a = 1'b0;
        check("busy_after_open", 64'(busy_a), 64'(1));

        push_good_writes_a();
        exp_ev_a.push_back('{done: 1'b1, err: 1'b0, code: 2'b00});
        send_bytes(fr_good);
        drain("good_frame");

        push_good_writes_a();
        exp_ev_a.push_back('{done: 1'b1, err: 1'b1, code: 2'b01});
        send_bytes(fr_bad);
        drain("bad_checksum");

        // Stalled write port: word 1 is dropped behind word 0.
        wr_ready = 1'b0;
        exp_wr_a.push_back('{addr: 32'h0000_1000, data: 32'h9350_0013});
        exp_ev_a.push_back('{done: 1'b1, err: 1'b1, code: 2'b10});
        send_bytes(fr_good);
        tick(2);
        check("ovf_event_seen", 64'(exp_ev_a.size()), 64'(0));
        check("ovf_pending_valid", 64'(wr_valid_a), 64'(1));
        check("ovf_pending_word", 64'({wr_addr_a, wr_data_a}), 64'h0000_1000_9350_0013);
        wr_ready = 1'b1;
        drain("ovf_retire");
        check("ovf_valid_dropped", 64'(wr_valid_a), 64'(0));

        // Restart mid-frame with win_open.
        send_bytes('{8'h00, 8'h10, 8'h00});
        win_open_a = 1'b1; tick(); win_open_a = 1'b0;
        push_good_writes_a();
        exp_ev_a.push_back('{done: 1'b1, err: 1'b0, code: 2'b00});
        send_bytes(fr_good);
        drain("restart");

        // Inter-byte timeout after 3 bytes.
        exp_ev_a.push_back('{done: 1'b0, err: 1'b1, code: 2'b11});
        send_bytes('{8'h00, 8'h10, 8'h00});
        d = byte_cyc;
        tick(60);
        check("timeout_event_seen", 64'(exp_ev_a.size()), 64'(0));
        d = last_ev_cyc_a - d;
        n_checks++;
        if (d < 50 || d > 51) begin
            n_fail++;
            $display("FAIL timeout_delay: got %0d cycles after last byte, expected 50..51", d);
        end
        check("timeout_back_to_hunt", 64'(busy_a), 64'(1));
        push_good_writes_a();
        exp_ev_a.push_back('{done: 1'b1, err: 1'b0, code: 2'b00});
        send_bytes(fr_good);
        drain("after_timeout");

        win_close_a = 1'b1; tick(); win_close_a = 1'b0;
        check("close_from_hunt", 64'(busy_a), 64'(0));
        win_open_a = 1'b1; win_close_a = 1'b1; tick();
        win_open_a = 1'b0; win_close_a = 1'b0;
        check("open_wins_over_close", 64'(busy_a), 64'(1));

        exp_ev_a.push_back('{done: 1'b0, err: 1'b1, code: 2'b11});
        send_bytes('{8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h13, 8'h00});
        win_close_a = 1'b1; tick(); win_close_a = 1'b0;
        check("close_mid_data_busy", 64'(busy_a), 64'(0));
        drain("close_mid_data");

        // Asynchronous reset with a word pending.
        win_open_a = 1'b1; tick(); win_open_a = 1'b0;
        wr_ready = 1'b0;
        send_bytes('{8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h13, 8'h00, 8'h50, 8'h93});
        tick();
        check("pre_reset_pending", 64'(wr_valid_a), 64'(1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_word", 64'({wr_addr_a, wr_data_a}), 64'(0));
        check("async_reset_flags",
              64'({wr_valid_a, busy_a, frame_done_a, frame_err_a, err_code_a}), 64'(0));
        tick();
        rst_n = 1'b1;
        wr_ready = 1'b1;
        tick(5);
        check("post_reset_quiet", 64'({wr_valid_a, busy_a}), 64'(0));

        // Big-endian 16-bit receiver with address wrap.
        win_open_b = 1'b1; tick(); win_open_b = 1'b0;
        check("busy_b_after_open", 64'(busy_b), 64'(1));
        exp_wr_b.push_back('{addr: 32'h0000_FFFE, data: 32'h0000_1234});
        exp_wr_b.push_back('{addr: 32'h0000_0000, data: 32'h0000_ABCD});
        exp_ev_b.push_back('{done: 1'b1, err: 1'b0, code: 2'b00});
        send_bytes(fr_b);
        drain("big_endian_wrap");

        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_burst_rx.md
INSTR_BURST_RX -- requirements
Module: instr_burst_rx

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width; a multiple of 8.
REQ-002 SHALL have parameter DATA_W, default 32, data word width; a multiple of 8.
REQ-003 SHALL have parameter BIG_ENDIAN, default 0; 0 = LSB byte first, 1 = MSB byte first, applied to address and data fields.
REQ-004 SHALL have parameter TIMEOUT, default 100000, inter-byte idle limit in cycles; 0 disables the timeout.
REQ-005 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- win_open  in  1  pulse; opens the receive window.
- win_close  in  1  pulse; closes the receive window.
- data_in_rx  in  8  received byte.
- rx_data_valid  in  1  byte strobe, level; its rising edge marks a new byte.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- wr_valid  out  1  write request.
- wr_ready  in  1  write accepted.
- busy  out  1  receive window open.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_err  out  1  one-cycle pulse on an errored or aborted frame.
- err_code  out  2  error cause; valid while frame_err=1.

Function
REQ-006 SHALL detect a byte as rx_data_valid & ~rx_data_valid_q, where rx_data_valid_q is registered, and SHALL sample data_in_rx in that same cycle.
REQ-007 SHALL implement states IDLE, HUNT, ADDR, LEN, DATA, CSUM.
- IDLE means window closed; HUNT means window open with no frame started.
REQ-008 SHALL implement the frame format AB = ADDR_W/8 address bytes, one length byte N (number of words), N×DB data bytes (DB = DATA_W/8), then one checksum byte.
REQ-009 SHALL take the following transitions:
- IDLE→HUNT on win_open.
- HUNT→ADDR on the first byte, which is counted as address byte 0.
- ADDR→LEN after AB bytes.
- LEN→DATA if N≠0, else LEN→CSUM.
- DATA→CSUM after N words.
- CSUM→HUNT on the checksum byte.
REQ-010 SHALL take win_close from any state to IDLE; if the state was ADDR/LEN/DATA/CSUM it SHALL pulse frame_err with err_code=2'b11.
REQ-011 SHALL give win_open priority when win_open and win_close occur in the same cycle.
REQ-012 SHALL restart a frame on win_open while not IDLE: go to HUNT, clear byte counter, checksum and sticky errors, with no frame_err pulse.
REQ-013 SHALL compute the checksum as the XOR of all address, length and data bytes of the frame.
REQ-014 SHALL, on the checksum byte, pulse frame_done for one cycle; frame_err SHALL pulse in the same cycle if the checksum mismatches or a sticky overflow is set.
- err_code priority: overflow 2'b10 over checksum 2'b01.
REQ-015 SHALL load wr_addr and wr_data and assert wr_valid the cycle after the final byte of each word is accepted.
- Word k SHALL use address header_addr + k×DB, wrapping modulo 2^ADDR_W.
REQ-016 SHALL hold wr_valid, wr_addr and wr_data stable until a cycle with wr_valid & wr_ready; wr_valid SHALL then deassert unless a new word loads in that same cycle.
REQ-017 SHALL, when a word completes while wr_valid=1 and wr_ready=0, drop the new word, keep the pending word, and set the sticky overflow error.
- wr_ready=1 in the completing cycle is not an overflow.
REQ-018 SHALL NOT cancel a word already presented: a pending wr_valid survives checksum errors, aborts, restarts and win_close.
REQ-019 SHALL, when TIMEOUT≠0 in ADDR/LEN/DATA/CSUM, count cycles since the last byte; on reaching TIMEOUT it SHALL go to HUNT and pulse frame_err with err_code=2'b11.
REQ-020 SHALL drive busy = (state≠IDLE).
REQ-021 SHALL hold err_code at 2'b00 whenever frame_err=0.

Reset
REQ-022 SHALL, while rst_n=0, asynchronously force:
- state to IDLE.
- all counters, the checksum, sticky errors and rx_data_valid_q to 0.
- wr_addr, wr_data, wr_valid, busy, frame_done, frame_err and err_code to 0.
REQ-023 SHALL discard an in-progress frame and a pending word on reset, with no frame_err pulse.
REQ-024 SHALL leave reset in IDLE and need a win_open before accepting bytes.

Structure
REQ-025 SHALL take the state enum and the err_code constants (NONE=00, CSUM=01, OVF=10, ABORT=11) from shared package instr_rx_pkg.
REQ-026 SHALL use one sub-module, instr_rx_asm: a byte-to-word shift assembler parametrised by width and BIG_ENDIAN, reused for the address and data fields.
REQ-027 SHALL size the timeout counter as $clog2(TIMEOUT+1) bits.

Verification
REQ-028 Defaults, LE, frame 00 10 00 00 | 02 | 13 00 50 93 | 00 00 00 13 | correct XOR:
- writes (0x00001000, 0x93500013) and (0x00001004, 0x13000000) are issued.
- frame_done pulses and frame_err stays 0.
REQ-029 Same frame with checksum byte corrupted by XOR 0x01:
- both writes are issued.
- frame_done and frame_err pulse together with err_code=01.
REQ-030 wr_ready held 0 through a 2-word frame:
- only word 0 stays presented.
- frame end gives err_code=10.
- wr_ready=1 then retires word 0 only.
REQ-031 TIMEOUT=50, stall of 60 cycles after 3 bytes:
- frame_err pulses with err_code=11 at cycle 50 after the last byte.
- state returns to HUNT; a following full frame succeeds.
REQ-032 Simultaneous and disruptive events:
- win_open and win_close in the same cycle leave busy=1.
- win_close mid-DATA gives err_code=11 and busy=0.
- rst_n=0 mid-frame zeroes all outputs immediately.
REQ-033 BIG_ENDIAN=1, ADDR_W=16, DATA_W=16, address FF FE, N=2:
- writes go to 0xFFFE then 0x0000 (wrap).
